alu_unit: RTL and testbench

- 32-bit RV32I-style integer ALU for the single-cycle datapath.
- Result is purely combinational from op and operands, so the single-cycle core uses it in the same cycle.
- A registered copy of the result is also provided for pipelined or debug consumers.
- Covers add/sub, shifts, logic, signed/unsigned set-less-than and an operand-B pass-through (LUI).

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_shifter.sv | 27 ++
 rtl/alu_unit.sv | 76 +++++++
 tb/tb_alu_unit.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I integer ALU: datapath width, op encoding
// and a bit-reversal helper used by the shifter.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101,
    ALU_LUI  = 4'b1111
  } alu_op_e;

  function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] value);
    logic [XLEN-1:0] reversed;
    reversed = '0;
    for (int i = 0; i < XLEN; i++) begin
      reversed[i] = value[XLEN-1-i];
    end
    return reversed;
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Shared five-stage barrel shifter. Left shifts reuse the right-shift stages
// by bit-reversing the data on the way in and on the way out.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] data,
  input  logic [4:0]      shamt,
  input  logic            dir_left,
  input  logic            arith,
  output logic [XLEN-1:0] result
);

  logic                 fill;
  logic [5:0][XLEN-1:0] stage;

  assign fill     = arith & data[XLEN-1];
  assign stage[0] = dir_left ? bit_reverse(data) : data;

  // Stage k shifts right by 2**k when shamt[k] is set.
  for (genvar k = 0; k < 5; k++) begin : g_stage
    localparam int SH = 1 << k;
    assign stage[k+1] = shamt[k] ? {{SH{fill}}, stage[k][XLEN-1:SH]} : stage[k];
  end

  assign result = dir_left ? bit_reverse(stage[5]) : stage[5];

endmodule

// File: rtl/alu_unit.sv
// RV32I integer ALU: zero-latency combinational result for the single-cycle
// core plus a registered copy for pipelined/debug consumers.
module alu_unit
  import alu_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [3:0]      i_alu_op,
  input  logic [XLEN-1:0] i_operand_a,
  input  logic [XLEN-1:0] i_operand_b,
  output logic [XLEN-1:0] o_alu_data,
  output logic [XLEN-1:0] o_alu_data_q
);

  alu_op_e         op;
  logic            sub;
  logic [XLEN-1:0] b_eff;
  logic [XLEN:0]   sum_ext;
  logic [XLEN-1:0] sum;
  logic            carry;
  logic            lt_signed;
  logic            lt_unsigned;
  logic [XLEN-1:0] shift_result;

  assign op = alu_op_e'(i_alu_op);

  // One adder serves ADD, SUB and both compares; subtraction is A + ~B + 1.
  assign sub     = (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
  assign b_eff   = i_operand_b ^ {XLEN{sub}};
  assign sum_ext = {1'b0, i_operand_a} + {1'b0, b_eff} + {{XLEN{1'b0}}, sub};
  assign sum     = sum_ext[XLEN-1:0];
  assign carry   = sum_ext[XLEN];

  // A borrow (no carry out) means A < B unsigned. For signed, differing sign
  // bits decide directly, which sidesteps overflow of the difference.
  assign lt_unsigned = ~carry;
  assign lt_signed   = (i_operand_a[XLEN-1] != i_operand_b[XLEN-1])
                     ? i_operand_a[XLEN-1] : sum[XLEN-1];

  alu_shifter u_shifter (
    .data     (i_operand_a),
    .shamt    (i_operand_b[4:0]),
    .dir_left (op == ALU_SLL),
    .arith    (op == ALU_SRA),
    .result   (shift_result)
  );

  always_comb begin
    // NOTE: default assigned first so every path drives o_alu_data and no latch is inferred.
    o_alu_data = '0;
    case (op)
      ALU_ADD,
      ALU_SUB:  o_alu_data = sum;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  o_alu_data = shift_result;
      ALU_XOR:  o_alu_data = i_operand_a ^ i_operand_b;
      ALU_OR:   o_alu_data = i_operand_a | i_operand_b;
      ALU_AND:  o_alu_data = i_operand_a & i_operand_b;
      ALU_SLT:  o_alu_data = {{(XLEN-1){1'b0}}, lt_signed};
      ALU_SLTU: o_alu_data = {{(XLEN-1){1'b0}}, lt_unsigned};
      ALU_LUI:  o_alu_data = i_operand_b;
      default:  o_alu_data = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: non-blocking assignment so the register samples the pre-edge value of o_alu_data.
    if (!i_rst_n) begin
      o_alu_data_q <= '0;
    end else begin
      o_alu_data_q <= o_alu_data;
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vectors, async reset behaviour
// and a random sweep, with a scoreboard queue for the registered output.
module tb_alu_unit;

  logic        clk;
  logic        rst_n;
  logic [3:0]  alu_op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] alu_data;
  logic [31:0] alu_data_q;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb[$];

  alu_unit dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_alu_op    (alu_op),
    .i_operand_a (operand_a),
    .i_operand_b (operand_b),
    .o_alu_data  (alu_data),
    .o_alu_data_q(alu_data_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h (op=%b a=%h b=%h)", tag, got, exp,
               alu_op, operand_a, operand_b);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb_v;
    logic [31:0]        r;
    sa   = a;
    sb_v = b;
    case (op)
      4'b0000: r = a + b;
      4'b1000: r = a - b;
      4'b0001: r = a << b[4:0];
      4'b0101: r = a >> b[4:0];
      4'b1101: r = sa >>> b[4:0];
      4'b0100: r = a ^ b;
      4'b0110: r = a | b;
      4'b0111: r = a & b;
      4'b0010: r = (sa < sb_v) ? 32'd1 : 32'd0;
      4'b0011: r = (a < b) ? 32'd1 : 32'd0;
      4'b1111: r = b;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Drive one vector between edges, check the combinational result, then
  // check the registered copy one rising edge later via the scoreboard.
  task automatic apply(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    logic [31:0] exp_q;
    @(negedge clk);
    alu_op    = op;
    operand_a = a;
    operand_b = b;
    #1;
    check({tag, "_comb"}, alu_data, exp);
    sb.push_back(exp);
    @(posedge clk);
    #1;
    exp_q = sb.pop_front();
    check({tag, "_q"}, alu_data_q, exp_q);
  endtask

  initial begin
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;

    rst_n     = 1'b0;
    alu_op    = 4'b0000;
    operand_a = 32'd0;
    operand_b = 32'd0;
    #1;
    check("reset_q", alu_data_q, 32'h0);
    check("reset_comb", alu_data, 32'h0);
    @(posedge clk);
    #1;
    check("reset_hold_q", alu_data_q, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    apply("add",        4'b0000, 32'd10,        32'd20,        32'd30);
    apply("sub_pos",    4'b1000, 32'd20,        32'd10,        32'd10);
    apply("sub_neg",    4'b1000, 32'd10,        32'd20,        32'hFFFF_FFF6);
    apply("add_wrap",   4'b0000, 32'hFFFF_FFFF, 32'd1,         32'h0);
    apply("sll",        4'b0001, 32'd1,         32'd5,         32'h20);
    apply("srl",        4'b0101, 32'h8000_0000, 32'd1,         32'h4000_0000);
    apply("sra",        4'b1101, 32'h8000_0000, 32'd1,         32'hC000_0000);
    apply("sra_ones",   4'b1101, 32'hFFFF_FFFF, 32'd4,         32'hFFFF_FFFF);
    apply("sll_hi_b",   4'b0001, 32'd1,         32'h25,        32'h20);
    apply("sll_zero",   4'b0001, 32'h1234_5678, 32'h0,         32'h1234_5678);
    apply("sra_31",     4'b1101, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF);
    apply("xor",        4'b0100, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF);
    apply("or",         4'b0110, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF);
    apply("and",        4'b0111, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0);
    apply("lui",        4'b1111, 32'h1111_1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    apply("unused1010", 4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    apply("slt_m1_1",   4'b0010, 32'hFFFF_FFFF, 32'd1,         32'd1);
    apply("slt_eq",     4'b0010, 32'd2,         32'd2,         32'd0);
    apply("slt_ovf",    4'b0010, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1);
    apply("slt_ovf_r",  4'b0010, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0);
    apply("sltu_lt",    4'b0011, 32'd1,         32'hFFFF_FFFF, 32'd1);
    apply("sltu_ge",    4'b0011, 32'hFFFF_FFFF, 32'd1,         32'd0);

    // Asynchronous reset between edges, with ADD 10+20 held on the inputs.
    @(negedge clk);
    alu_op    = 4'b0000;
    operand_a = 32'd10;
    operand_b = 32'd20;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_q", alu_data_q, 32'h0);
    check("async_rst_comb", alu_data, 32'd30);
    sb.delete();
    @(posedge clk);
    #1;
    check("rst_held_q", alu_data_q, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_q", alu_data_q, 32'h0);
    check("rst_release_comb", alu_data, 32'd30);
    @(posedge clk);
    #1;
    check("first_edge_q", alu_data_q, 32'd30);

    // Random sweep over all 16 op codes, with occasional corner operands.
    for (int i = 0; i < 10000; i++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = $urandom();
      r_b  = $urandom();
      case ($urandom_range(0, 7))
        0: r_a = 32'h8000_0000;
        1: r_b = 32'h7FFF_FFFF;
        2: r_a = r_b;
        3: r_b = 32'hFFFF_FFFF;
        default: ;
      endcase
      apply("rnd", r_op, r_a, r_b, model(r_op, r_a, r_b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
